// File: rtl/gemm_pkg.sv
// Shared types and saturation helpers for the GEMM output drain.
package gemm_pkg;

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

    // Signed saturation bounds for a w-bit requantized lane (w <= 31).
    function automatic int sat_hi(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int DEF_OUT_WIDTH = 8;
    localparam int DEF_SAT_HI    = sat_hi(DEF_OUT_WIDTH);
    localparam int DEF_SAT_LO    = sat_lo(DEF_OUT_WIDTH);

endpackage

// File: rtl/gemm_drain_lane.sv
// Per-lane requantizer: round-half-up arithmetic right shift, then signed saturation.
module gemm_drain_lane
    import gemm_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [4:0]           shift,
    output logic [OUT_WIDTH-1:0] q
);
    localparam logic signed [ACC_WIDTH:0] HI = (ACC_WIDTH+1)'(sat_hi(OUT_WIDTH));
    localparam logic signed [ACC_WIDTH:0] LO = (ACC_WIDTH+1)'(sat_lo(OUT_WIDTH));

    logic signed [ACC_WIDTH:0] ext, rnd, r;

    // One extra bit keeps acc + rounding term from wrapping.
    always_comb begin
        ext = {acc[ACC_WIDTH-1], acc};
        rnd = '0;
        if (shift != 5'd0)
            rnd = (ACC_WIDTH+1)'(1) << (shift - 5'd1);
        r = (ext + rnd) >>> shift;
        if (r > HI)
            q = HI[OUT_WIDTH-1:0];
        else if (r < LO)
            q = LO[OUT_WIDTH-1:0];
        else
            q = r[OUT_WIDTH-1:0];
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a write into a full FIFO succeeds only when paired with a read.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic wr_ok, rd_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_en);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_ok)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !rd_ok)
                count <= count + 1'b1;
            else if (rd_ok && !wr_ok)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/gemm_drain.sv
// Systolic-array drain: deskew lanes, requantize, buffer vectors, and sequence one tile.
module gemm_drain
    import gemm_pkg::*;
#(
    parameter int ARRAY_N    = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [15:0]                    num_vec,
    input  logic [4:0]                     shift,
    input  logic                           in_valid,
    input  logic [ARRAY_N*ACC_WIDTH-1:0]   psum_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ARRAY_N*OUT_WIDTH-1:0]   out_data,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow
);
    localparam int STAGES = ARRAY_N - 1;  // ARRAY_N >= 2

    state_t state, nstate;
    logic [15:0] nv_q, vec_cnt;
    logic [4:0]  shift_q;
    logic [STAGES:1] vld_pipe;
    logic [ARRAY_N-1:0][ACC_WIDTH-1:0] aligned;
    logic [ARRAY_N-1:0][OUT_WIDTH-1:0] rq, q_data;
    logic q_vld, start_ok, vec_in, fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign start_ok = start && (state == IDLE);
    assign vec_in   = vld_pipe[STAGES] && (state == DRAIN);

    // Lane i waits ARRAY_N-1-i cycles so every lane lines up with the last one.
    for (genvar i = 0; i < ARRAY_N; i++) begin : g_lane
        localparam int DLY = ARRAY_N - 1 - i;
        if (DLY == 0) begin : g_pass
            assign aligned[i] = psum_in[i*ACC_WIDTH +: ACC_WIDTH];
        end else begin : g_dly
            logic [DLY-1:0][ACC_WIDTH-1:0] dly;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dly <= '0;
                end else begin
                    dly[0] <= psum_in[i*ACC_WIDTH +: ACC_WIDTH];
                    for (int k = 1; k < DLY; k++)
                        dly[k] <= dly[k-1];
                end
            end
            assign aligned[i] = dly[DLY-1];
        end
        gemm_drain_lane #(.ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_lane (
            .acc   (aligned[i]),
            .shift (shift_q),
            .q     (rq[i])
        );
    end

    sync_fifo #(.WIDTH(ARRAY_N*OUT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (q_vld),
        .wr_data (q_data),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            vld_pipe <= '0;
            nv_q     <= '0;
            shift_q  <= '0;
            vec_cnt  <= '0;
            q_vld    <= 1'b0;
            q_data   <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= nstate;
            vld_pipe[1] <= in_valid;
            for (int k = 2; k <= STAGES; k++)
                vld_pipe[k] <= vld_pipe[k-1];
            q_vld  <= vec_in;
            q_data <= rq;
            if (start_ok) begin
                nv_q     <= num_vec;
                shift_q  <= shift;
                vec_cnt  <= '0;
                overflow <= 1'b0;
            end else begin
                if (vec_in)
                    vec_cnt <= vec_cnt + 16'd1;
                // Dropped vectors were already counted when they aligned.
                if (q_vld && fifo_full && !out_ready)
                    overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:  if (start) nstate = (num_vec == 16'd0) ? DONE : DRAIN;
            DRAIN: if (vec_in && (vec_cnt + 16'd1) == nv_q) nstate = FLUSH;
            // The last vector may still sit in the output register.
            FLUSH: if (fifo_empty && !q_vld) nstate = DONE;
            DONE:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

endmodule

// File: doc/gemm_drain.md
GEMM_DRAIN -- requirements
Module: gemm_drain

Interface
REQ-001 SHALL have parameter ARRAY_N, default 4, meaning the number of systolic lanes drained in parallel.
REQ-002 SHALL have parameter ACC_WIDTH, default 32, meaning the partial-sum width per lane.
REQ-003 SHALL have parameter OUT_WIDTH, default 8, meaning the signed requantized output width per lane.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of output vector entries (power of 2).
REQ-005 SHALL have port clk  input  1  meaning the single clock; all state is on its rising edge.
REQ-006 SHALL have port rst_n  input  1  meaning the asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  meaning a pulse that begins a tile drain; it is ignored unless the state is IDLE.
REQ-008 SHALL have port num_vec  input  16  meaning the count of result vectors in the tile, sampled on start; 0 means done immediately.
REQ-009 SHALL have port shift  input  5  meaning the requantization right-shift, sampled on start.
REQ-010 SHALL have port in_valid  input  1  meaning the lane-0 element of a vector is present this cycle.
REQ-011 SHALL have port psum_in  input  ARRAY_N*ACC_WIDTH  meaning the skewed partial sums; lane i occupies bits [i*ACC_WIDTH +: ACC_WIDTH] and arrives i cycles after lane 0.
REQ-012 SHALL have port out_valid  output  1  meaning the FIFO head holds a vector.
REQ-013 SHALL have port out_ready  input  1  meaning the consumer accepts the head; transfer occurs when out_valid and out_ready are both 1.
REQ-014 SHALL have port out_data  output  ARRAY_N*OUT_WIDTH  meaning the aligned requantized vector, lane i at [i*OUT_WIDTH +: OUT_WIDTH].
REQ-015 SHALL have port busy  output  1  meaning the state is not IDLE.
REQ-016 SHALL have port done  output  1  meaning a one-cycle pulse on entering DONE.
REQ-017 SHALL have port overflow  output  1  meaning a sticky flag set when a vector is dropped because the FIFO is full; cleared by an accepted start.

Function
REQ-018 SHALL deskew with a per-lane delay line of ARRAY_N-1-i registers for lane i, so that all lanes of one vector align ARRAY_N-1 cycles after lane 0; in_valid SHALL be delayed identically.
REQ-019 SHALL requantize each aligned lane as follows: compute r = (acc + 2^(shift-1)) >>> shift in ACC_WIDTH+1 bits, arithmetic, when shift>0, or r = acc when shift=0; then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-020 SHALL register the requantized vector and write it to the FIFO on the edge exactly ARRAY_N cycles after the edge that sampled lane-0 in_valid.
REQ-021 SHALL drive out_valid from registered FIFO state, so that it rises the cycle after a write into an empty FIFO; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 SHALL allow a simultaneous FIFO write and read when full: the read frees the slot, the write succeeds, and the count is unchanged.
REQ-023 SHALL, on a write while full without a simultaneous read, drop the vector, set overflow, and still count the vector toward num_vec.
REQ-024 SHALL implement states IDLE, DRAIN, FLUSH and DONE with these transitions:
- IDLE->DRAIN on start with num_vec>0; IDLE->DONE on start with num_vec=0.
- DRAIN->FLUSH when the vector counter reaches num_vec.
- FLUSH->DONE when the FIFO is empty.
- DONE->IDLE after one cycle.
REQ-025 SHALL count only aligned-valid vectors arriving in DRAIN; aligned-valid vectors in other states SHALL be discarded without setting overflow.
REQ-026 SHALL keep the FIFO readable in every state.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear the state to IDLE, the delay lines, counters, FIFO pointers, out_valid, out_data, busy, done and overflow to 0.
REQ-028 SHALL discard any partially deskewed or buffered data on reset mid-drain.

Structure
REQ-029 SHALL place the state enum and the saturation limit constants in a shared package named gemm_pkg.
REQ-030 SHALL implement the buffer as a sub-module sync_fifo (parameters WIDTH, DEPTH) with full/empty/count outputs.

Verification
REQ-031 SHALL cover: N=4, shift=0, one vector {10,-3,127,-128} skewed -> out_data equals the same values, out_valid rises 5 cycles after lane-0 in_valid, then done.
REQ-032 SHALL cover: shift=4, acc=24 -> 2 (rounded from 1.5), acc=-24 -> -1, acc=1000000 -> 127, acc=-1000000 -> -128.
REQ-033 SHALL cover: num_vec=8, back-to-back vectors, out_ready=1 -> 8 outputs in order, no overflow, a single done pulse.
REQ-034 SHALL cover: num_vec=6, out_ready=0 -> 4 vectors buffered, 2 dropped, overflow=1, FSM holds FLUSH until out_ready=1 drains 4.
REQ-035 SHALL cover: rst_n low mid-DRAIN -> all outputs 0 next sample, state IDLE, and a subsequent start drains correctly.
REQ-036 SHALL cover: start with num_vec=0 -> done pulse within 2 cycles; start while busy -> ignored.
